// File: rtl/mips_defs.sv
// Shared MIPS encoding constants for the P6 decode front end.
// Opcode, funct and REGIMM field values plus the next-PC select codes driven to fetch.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [3:0] PCSEL_PC4  = 4'd0;
    localparam logic [3:0] PCSEL_BR   = 4'd1;
    localparam logic [3:0] PCSEL_J    = 4'd2;
    localparam logic [3:0] PCSEL_JR   = 4'd3;

    // True for every encoding that resolves as a conditional branch.
    function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ) ||
               ((op == OP_REGIMM) && ((rt == RT_BLTZ) || (rt == RT_BGEZ)));
    endfunction

endpackage

// File: rtl/id_branch_stage_branch_cmp.sv
// Branch condition evaluator: compares the forwarded operands according to the branch opcode.
// Produces 0 for anything that is not a recognised conditional branch.
module branch_cmp
    import mips_defs::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rt,
    input  logic [31:0] rs_fwd,
    input  logic [31:0] rt_fwd,
    output logic        ifequal
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs_fwd == 32'd0);
    assign rs_neg  = rs_fwd[31];

    always_comb begin
        ifequal = 1'b0;
        case (op)
            OP_BEQ:    ifequal = (rs_fwd == rt_fwd);
            OP_BNE:    ifequal = (rs_fwd != rt_fwd);
            OP_BLEZ:   ifequal = rs_neg || rs_zero;
            OP_BGTZ:   ifequal = !rs_neg && !rs_zero;
            OP_REGIMM: begin
                if (rt == RT_BLTZ)      ifequal = rs_neg;
                else if (rt == RT_BGEZ) ifequal = !rs_neg;
            end
            default:   ifequal = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_branch_stage.sv
// IF/ID pipeline register with same-cycle branch/jump resolution for the fetch unit.
// Delay-slot semantics: a taken branch never flushes the instruction already fetched.
module id_branch_stage
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc8_f,
    input  logic        stall,
    input  logic        clr,
    input  logic [31:0] rs_fwd,
    input  logic [31:0] rt_fwd,
    output logic [31:0] instr_d,
    output logic [31:0] pc8_d,
    output logic [3:0]  PCsel,
    output logic        ifequal,
    output logic [25:0] imm,
    output logic [31:0] BUSA
);

    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       cmp_true;

    // clr outranks stall so a squashed slot never lingers in D.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d <= 32'd0;
            pc8_d   <= 32'd0;
        end else if (clr) begin
            instr_d <= 32'd0;
            pc8_d   <= 32'd0;
        end else if (!stall) begin
            instr_d <= instr_f;
            pc8_d   <= pc8_f;
        end
    end

    assign op    = instr_d[31:26];
    assign rt    = instr_d[20:16];
    assign funct = instr_d[5:0];

    always_comb begin
        PCsel = PCSEL_PC4;
        if (is_branch(op, rt))
            PCsel = PCSEL_BR;
        else if ((op == OP_J) || (op == OP_JAL))
            PCsel = PCSEL_J;
        else if ((op == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR)))
            PCsel = PCSEL_JR;
    end

    branch_cmp u_branch_cmp (
        .op      (op),
        .rt      (rt),
        .rs_fwd  (rs_fwd),
        .rt_fwd  (rt_fwd),
        .ifequal (cmp_true)
    );

    assign ifequal = (PCsel == PCSEL_BR) && cmp_true;
    assign imm     = instr_d[25:0];
    assign BUSA    = rs_fwd;

endmodule

// File: doc/id_branch_stage.md
# id_branch_stage

Decode-stage front end of the P6 pipeline. It is the IF/ID pipeline register that captures `instruction` and `PCadd8` from the fetch unit, with stall and clear support. From the held instruction and forwarded register values it resolves branch and jump control in the same cycle. It drives `PCsel`, `ifequal`, `imm` and `BUSA` back into the fetch unit, and forwards the held instruction and PC+8 to the execute stage. MIPS delay-slot semantics apply: a taken branch never flushes the fetched slot instruction.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `instr_f`  in  32  instruction from fetch (`instruction`).
- `pc8_f`  in  32  fetch-stage PC+8, already biased by 0x3000 (`PCadd8`).
- `stall`  in  1  hazard-unit stall; hold the IF/ID register.
- `clr`  in  1  synchronous clear of the IF/ID register to NOP.
- `rs_fwd`  in  32  forwarded GPR[rs] value for the held instruction.
- `rt_fwd`  in  32  forwarded GPR[rt] value for the held instruction.
- `instr_d`  out  32  held instruction, to execute stage and hazard unit.
- `pc8_d`  out  32  held PC+8, to execute stage (jal/jalr link value).
- `PCsel`  out  4  next-PC select to fetch: 0 = +4, 1 = branch, 2 = j/jal, 3 = jr/jalr.
- `ifequal`  out  1  branch condition true; meaningful only when `PCsel` = 1.
- `imm`  out  26  `instr_d[25:0]`.
- `BUSA`  out  32  jump-register target, equal to `rs_fwd`.

## Operation
- **Register update** on each rising edge without reset, in priority order:
  - `clr` = 1: `instr_d` ← 0 (NOP), `pc8_d` ← 0.
  - else `stall` = 1: both registers hold their values.
  - else: `instr_d` ← `instr_f`, `pc8_d` ← `pc8_f`.
- **Reset values:** `instr_d` = 0 and `pc8_d` = 0. Consequently `PCsel` = 0, `ifequal` = 0, `imm` = 0, and `BUSA` follows `rs_fwd`.
- **Decode** is combinational from `instr_d` only. Fields: `op` = [31:26], `rt` = [20:16], `funct` = [5:0].
  - op 000100 beq: `PCsel` = 1, `ifequal` = (rs == rt).
  - op 000101 bne: `PCsel` = 1, `ifequal` = (rs != rt).
  - op 000110 blez: `PCsel` = 1, `ifequal` = signed rs ≤ 0.
  - op 000111 bgtz: `PCsel` = 1, `ifequal` = signed rs > 0.
  - op 000001, rt field 00000 bltz: `PCsel` = 1, `ifequal` = rs[31].
  - op 000001, rt field 00001 bgez: `PCsel` = 1, `ifequal` = !rs[31].
  - op 000010 j / 000011 jal: `PCsel` = 2.
  - op 000000, funct 001000 jr / 001001 jalr: `PCsel` = 3.
  - Everything else, including NOP and unknown REGIMM rt values: `PCsel` = 0, `ifequal` = 0.
- **Operand rules:**
  - All comparisons use the full 32-bit `rs_fwd` and `rt_fwd`; signed compares are two's complement.
  - `ifequal` is forced to 0 whenever `PCsel` ≠ 1.
- **Stall:** decode outputs keep reflecting the held instruction. The external hazard unit deasserts `PCEn` so the fetch unit ignores them. No decode-output gating on `stall`.
- **Simultaneous `clr` and `stall`:** `clr` wins.

## Timing
- IF/ID latency is 1 cycle: `instr_f` present at edge N appears on `instr_d` after edge N.
- `PCsel`, `ifequal`, `imm` and `BUSA` are combinational from `instr_d`, `rs_fwd` and `rt_fwd`, with zero-cycle latency. The fetch unit samples them at the next edge.
- Branch/jump resolution happens in D. The delay-slot instruction is fetched in the same cycle and enters D on the following edge; no bubble is inserted.
- Asynchronous reset asserted mid-stall or mid-branch forces NOP outputs immediately. The first capture occurs on the first edge after `reset` deasserts.
- There are no combinational paths from `instr_f` or `pc8_f` to any output.

## Structure
- Shared package `mips_defs` holds:
  - opcode constants `OP_SPECIAL`, `OP_REGIMM`, `OP_BEQ`, `OP_BNE`, `OP_BLEZ`, `OP_BGTZ`, `OP_J`, `OP_JAL`;
  - funct constants `FN_JR`, `FN_JALR`;
  - REGIMM constants `RT_BLTZ`, `RT_BGEZ`;
  - PCsel constants `PCSEL_PC4`, `PCSEL_BR`, `PCSEL_J`, `PCSEL_JR`.
- Sub-module `branch_cmp` is the natural split: inputs `op`, `rt` field, `rs_fwd`, `rt_fwd`; output `ifequal`. The top level holds the register and the PCsel decode.

## Test plan
- Reset asserted asynchronously between edges → `instr_d` = 0, `pc8_d` = 0 and `PCsel` = 0 immediately, before any clock edge.
- `instr_f` = 0x10220003 (beq $1,$2), `rs_fwd` = `rt_fwd` = 5 → after one edge `PCsel` = 1, `ifequal` = 1, `imm` = 0x0220003. Change `rt_fwd` to 6 → `ifequal` = 0 in the same cycle.
- blez with `rs_fwd` = 0x80000000 → `ifequal` = 1. bgtz with `rs_fwd` = 0 → `ifequal` = 0. bgez with `rs_fwd` = 0 → `ifequal` = 1.
- `instr_f` = 0x03E00008 (jr $31), `rs_fwd` = 0x00003010 → `PCsel` = 3, `BUSA` = 0x00003010. jal 0x0C000C04 → `PCsel` = 2, `imm` = 0x0000C04.
- Load addu, hold `stall` = 1 for 3 cycles while `instr_f` changes → `instr_d` and `pc8_d` unchanged. Release → next `instr_f` is captured.
- `clr` and `stall` both 1 while holding beq → `instr_d` = 0 after the edge, and `PCsel` = 0.
